// File: rtl/if_fetch_cache_if.sv
// if_fetch_cache_if: fetch-side bus between the IF stage
// and the memory controller's instruction port.
interface if_fetch_cache_if;
  logic        if_read;
  logic [31:0] if_addr;
  logic        if_discard;
  logic        if_busy;
  logic        if_ready;
  logic [31:0] if_data;

  modport master (
    output if_read,
    output if_addr,
    output if_discard,
    input  if_busy,
    input  if_ready,
    input  if_data
  );

  modport slave (
    input  if_read,
    input  if_addr,
    input  if_discard,
    output if_busy,
    output if_ready,
    output if_data
  );
endinterface

// File: rtl/if_fetch_cache.sv
// if_fetch_cache: instruction-fetch stage with a direct-mapped
// one-word-per-line cache, PC, redirect and stall handling.
module if_fetch_cache #(
  parameter int          CACHE_LINES = 128,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  if_fetch_cache_if.master mem,
  output logic             id_valid,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc
);

  localparam int INDEX_BITS = $clog2(CACHE_LINES);
  localparam int TAG_BITS   = 30 - INDEX_BITS;

  typedef enum logic {
    LOOKUP,
    MISS
  } state_t;

  state_t state;

  logic [31:0] pc;
  logic [31:0] miss_addr;

  logic [CACHE_LINES-1:0] line_valid;
  logic [TAG_BITS-1:0]    line_tag  [CACHE_LINES];
  logic [31:0]            line_data [CACHE_LINES];

  logic [INDEX_BITS-1:0] pc_index;
  logic [TAG_BITS-1:0]   pc_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;
  logic                  fill;

  assign pc_index   = pc[INDEX_BITS+1:2];
  assign pc_tag     = pc[31:INDEX_BITS+2];
  assign fill_index = miss_addr[INDEX_BITS+1:2];
  assign fill_tag   = miss_addr[31:INDEX_BITS+2];

  assign hit = line_valid[pc_index]
            && (line_tag[pc_index] == pc_tag);

  // A returning word is written even when a jump lands on
  // the same cycle: it is still correct for miss_addr.
  assign fill = (state == MISS) && mem.if_ready && !reset;

  assign mem.if_read    = (state == MISS);
  assign mem.if_addr    = miss_addr;
  assign mem.if_discard = jump && !reset
                       && (state == MISS) && !mem.if_ready;

  // if_busy is informational and the low target bits are
  // always forced to zero, so neither feeds any logic.
  wire unused_ok = ^{mem.if_busy, jump_target[1:0]};

  // Tag and data storage: written on fill, never reset.
  always_ff @(posedge clock) begin
    if (fill) begin
      line_tag[fill_index]  <= fill_tag;
      line_data[fill_index] <= mem.if_data;
    end
  end

  // Line valid bits: cleared only by reset, set on fill.
  always_ff @(posedge clock) begin
    if (reset) begin
      line_valid <= '0;
    end else if (fill) begin
      line_valid[fill_index] <= 1'b1;
    end
  end

  // Fetch control: PC, miss tracking and decode registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= LOOKUP;
      pc        <= RESET_PC;
      miss_addr <= '0;
      id_valid  <= 1'b0;
      id_inst   <= '0;
      id_pc     <= '0;
    end else if (jump) begin
      state    <= LOOKUP;
      pc       <= {jump_target[31:2], 2'b00};
      id_valid <= 1'b0;
    end else begin
      unique case (state)
        LOOKUP: begin
          if (hit) begin
            if (!stall) begin
              id_valid <= 1'b1;
              id_inst  <= line_data[pc_index];
              id_pc    <= pc;
              pc       <= pc + 32'd4;
            end
          end else begin
            if (!stall) begin
              id_valid <= 1'b0;
            end
            miss_addr <= pc;
            state     <= MISS;
          end
        end
        MISS: begin
          if (!stall) begin
            id_valid <= 1'b0;
          end
          if (mem.if_ready) begin
            state <= LOOKUP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_cache.sv
// tb_if_fetch_cache: directed scenarios plus random traffic
// against a transaction-level model of the fetch cache.
module tb_if_fetch_cache;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        stall;
  logic        jump;
  logic [31:0] jump_target;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  if_fetch_cache_if bus();

  if_fetch_cache #(
    .CACHE_LINES(128),
    .RESET_PC(32'h0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .jump(jump),
    .jump_target(jump_target),
    .mem(bus),
    .id_valid(id_valid),
    .id_inst(id_inst),
    .id_pc(id_pc)
  );

  int total = 0;
  int bad   = 0;

  // model: cache as index -> cached word address
  bit          m_known;
  bit          m_missing;
  bit          m_id_valid;
  logic [31:0] m_pc;
  logic [31:0] m_miss_addr;
  logic [31:0] m_id_pc;
  logic [31:0] m_line [int];

  // memory responder
  int req_age = -1;
  int req_lat = 0;
  int lat_cfg = 5;
  int req_to0 = 0;
  int req_to200 = 0;
  bit cur_rdy;

  function automatic logic [31:0] memfn(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13;
  endfunction

  function automatic int idx_of(logic [31:0] a);
    return int'((a >> 2) & 32'd127);
  endfunction

  task automatic check(bit ok, string nm,
                       logic [31:0] act, logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_step(bit r, bit j, logic [31:0] t,
                            bit s, bit rdy);
    bit h;
    if (r) begin
      m_known     = 1'b1;
      m_pc        = 32'h0;
      m_missing   = 1'b0;
      m_miss_addr = 32'h0;
      m_id_valid  = 1'b0;
      m_id_pc     = 32'h0;
      m_line.delete();
      return;
    end
    if (!m_known) return;
    if (m_missing && rdy)
      m_line[idx_of(m_miss_addr)] = m_miss_addr;
    if (j) begin
      m_pc       = {t[31:2], 2'b00};
      m_id_valid = 1'b0;
      m_missing  = 1'b0;
    end else if (!m_missing) begin
      h = m_line.exists(idx_of(m_pc))
       && (m_line[idx_of(m_pc)] == m_pc);
      if (h) begin
        if (!s) begin
          m_id_valid = 1'b1;
          m_id_pc    = m_pc;
          m_pc       = m_pc + 32'd4;
        end
      end else begin
        if (!s) m_id_valid = 1'b0;
        m_missing   = 1'b1;
        m_miss_addr = m_pc;
      end
    end else begin
      if (rdy) m_missing = 1'b0;
      if (!s) m_id_valid = 1'b0;
    end
  endtask

  // mode: 0 auto latency, 1 force ready, 2 withhold ready
  task automatic cycle(bit r, bit j, logic [31:0] t,
                       bit s, int mode);
    bit exp_disc;
    @(posedge clock);
    #1;
    reset       = r;
    jump        = j;
    jump_target = t;
    stall       = s;
    cur_rdy     = 1'b0;
    if (bus.if_read === 1'b1) begin
      if (req_age < 0) begin
        req_age = 0;
        req_lat = (lat_cfg > 0) ? lat_cfg
                                : int'($urandom_range(1, 6));
        if (bus.if_addr === 32'h0) req_to0++;
        if (bus.if_addr === 32'h200) req_to200++;
      end else begin
        req_age++;
      end
      cur_rdy = (mode == 1)
             || (mode == 0 && req_age + 1 >= req_lat);
      if (cur_rdy) req_age = -1;
    end else begin
      req_age = -1;
    end
    bus.if_ready = cur_rdy;
    bus.if_data  = cur_rdy ? memfn(bus.if_addr) : $urandom;
    bus.if_busy  = 1'($urandom_range(0, 1));
    @(negedge clock);
    if (m_known) begin
      exp_disc = j && !r && m_missing && !cur_rdy;
      check(bus.if_read === m_missing, "if_read",
            {31'b0, bus.if_read}, {31'b0, m_missing});
      if (m_missing)
        check(bus.if_addr === m_miss_addr, "if_addr",
              bus.if_addr, m_miss_addr);
      check(bus.if_discard === exp_disc, "if_discard",
            {31'b0, bus.if_discard}, {31'b0, exp_disc});
      check(id_valid === m_id_valid, "id_valid",
            {31'b0, id_valid}, {31'b0, m_id_valid});
      if (m_id_valid) begin
        check(id_pc === m_id_pc, "id_pc", id_pc, m_id_pc);
        check(id_inst === memfn(m_id_pc), "id_inst",
              id_inst, memfn(m_id_pc));
      end
    end
    model_step(r, j, t, s, cur_rdy);
  endtask

  task automatic wait_valid(logic [31:0] a, int maxc,
                            string nm);
    for (int i = 0; i < maxc; i++) begin
      if (id_valid === 1'b1 && id_pc === a) break;
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 0);
    end
    check(id_valid === 1'b1 && id_pc === a, nm, id_pc, a);
  endtask

  task automatic wait_req(logic [31:0] a, int mode, int maxc,
                          string nm);
    for (int i = 0; i < maxc; i++) begin
      if (bus.if_read === 1'b1 && bus.if_addr === a) break;
      cycle(1'b0, 1'b0, 32'h0, 1'b0, mode);
    end
    check(bus.if_read === 1'b1 && bus.if_addr === a, nm,
          bus.if_addr, a);
  endtask

  initial begin
    logic [31:0] pool [7];
    int          reads;
    bit          r;
    bit          j;
    bit          s;
    logic [31:0] t;

    pool = '{32'h0, 32'h40, 32'h100, 32'h200,
             32'h3F0, 32'hFFFF_FFF0, 32'h1000};
    reset        = 1'b1;
    stall        = 1'b0;
    jump         = 1'b0;
    jump_target  = 32'h0;
    bus.if_ready = 1'b0;
    bus.if_data  = 32'h0;
    bus.if_busy  = 1'b0;

    // cold start
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check(id_valid === 1'b0, "rst id_valid",
          {31'b0, id_valid}, 32'h0);
    check(id_pc === 32'h0 && id_inst === 32'h0, "rst id_*",
          id_pc | id_inst, 32'h0);
    check(bus.if_read === 1'b0, "rst if_read",
          {31'b0, bus.if_read}, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check(bus.if_read === 1'b1 && bus.if_addr === 32'h0,
          "cold req", bus.if_addr, 32'h0);
    wait_valid(32'h0, 12, "cold id_pc");
    check(id_inst === 32'h00000013, "cold id_inst",
          id_inst, 32'h00000013);
    wait_req(32'h4, 0, 5, "miss at 4");
    wait_valid(32'h8, 30, "prefill 8");

    // warm loop
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 0);
    wait_valid(32'h0, 5, "warm 0");
    check(bus.if_read === 1'b0, "warm rd0",
          {31'b0, bus.if_read}, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check(id_valid === 1'b1 && id_pc === 32'h4
          && bus.if_read === 1'b0, "warm 4", id_pc, 32'h4);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check(id_valid === 1'b1 && id_pc === 32'h8
          && bus.if_read === 1'b0, "warm 8", id_pc, 32'h8);

    // stall while id_pc=4
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 0);
    wait_valid(32'h0, 5, "stall pre");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 0);
      check(id_valid === 1'b1 && id_pc === 32'h4
            && id_inst === memfn(32'h4), "stall hold",
            id_pc, 32'h4);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check(id_pc === 32'h4, "stall last", id_pc, 32'h4);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check(id_valid === 1'b1 && id_pc === 32'h8,
          "stall resume", id_pc, 32'h8);

    // jump during miss
    cycle(1'b0, 1'b1, 32'h40, 1'b0, 2);
    wait_req(32'h40, 2, 5, "miss 0x40");
    cycle(1'b0, 1'b1, 32'h100, 1'b0, 2);
    check(bus.if_discard === 1'b1, "discard",
          {31'b0, bus.if_discard}, 32'h1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 2);
    check(bus.if_read === 1'b0, "read drop",
          {31'b0, bus.if_read}, 32'h0);
    wait_req(32'h100, 2, 5, "req 0x100");
    cycle(1'b0, 1'b1, 32'h40, 1'b0, 2);
    wait_req(32'h40, 2, 5, "0x40 not filled");

    // jump coincident with if_ready
    cycle(1'b0, 1'b1, 32'h100, 1'b0, 1);
    check(bus.if_discard === 1'b0, "coinc discard",
          {31'b0, bus.if_discard}, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 2);
    check(id_valid === 1'b0 && bus.if_read === 1'b0,
          "coinc idle", {31'b0, id_valid}, 32'h0);
    wait_req(32'h100, 0, 5, "coinc req 0x100");
    wait_valid(32'h100, 20, "fill 0x100");
    cycle(1'b0, 1'b1, 32'h40, 1'b0, 0);
    reads = 0;
    for (int i = 0; i < 4; i++) begin
      if (id_valid === 1'b1 && id_pc === 32'h40) break;
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 0);
      if (bus.if_read === 1'b1) reads++;
    end
    check(id_valid === 1'b1 && id_pc === 32'h40 && reads == 0,
          "0x40 hit", id_pc, 32'h40);

    // reset mid-miss
    cycle(1'b0, 1'b1, 32'h300, 1'b0, 2);
    wait_req(32'h300, 2, 5, "miss 0x300");
    req_to0   = 0;
    req_to200 = 0;
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 2);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 2);
    check(bus.if_read === 1'b0 && id_valid === 1'b0,
          "midmiss rst", {31'b0, bus.if_read}, 32'h0);
    wait_req(32'h0, 2, 3, "rst line inval");

    // conflict 0x000 / 0x200
    wait_valid(32'h0, 12, "conf 0");
    cycle(1'b0, 1'b1, 32'h200, 1'b0, 0);
    wait_valid(32'h200, 15, "conf 200");
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 0);
    wait_valid(32'h0, 15, "conf 0 again");
    check(req_to0 == 2, "conf req0", 32'(req_to0), 32'd2);
    check(req_to200 == 1, "conf req200",
          32'(req_to200), 32'd1);

    // PC wrap
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 0);
    wait_valid(32'hFFFF_FFFC, 15, "wrap top");
    wait_valid(32'h0, 15, "wrap zero");

    // random traffic
    lat_cfg = 0;
    for (int n = 0; n < 4000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      j = ($urandom_range(0, 11) == 0);
      s = ($urandom_range(0, 3) == 0);
      t = pool[$urandom_range(0, 6)]
        + ($urandom_range(0, 15) << 2)
        + $urandom_range(0, 3);
      cycle(r, j, t, s, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
